// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver that turns make/break sequences into menu key codes.
// Define PS2_PARITY_CHECK_EN to reject frames whose data plus parity bits are not odd.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] keyboard_out,
    output logic       key_valid,
    output logic       frame_err
);
    // state  | meaning
    // IDLE   | line idle, waiting for a start bit
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the parity bit
    // STOP   | checking the stop bit, then handing the byte on
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic            clk_s1, clk_s2, clk_d;
    logic            data_s1, data_s2;
    logic            fall;

    state_t          state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shift, shift_n;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;
    logic            frame_ok;
    logic            byte_done, err_n;
    logic            byte_valid;
    logic [7:0]      byte_reg;

    logic            ext, brk;
    logic [3:0]      code, key_n;

    // Synchroniser flops reset high so a released reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall        = clk_d & ~clk_s2;
    assign timeout_hit = (state != IDLE) && (to_cnt >= TO_LIMIT);

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit, par_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_bit <= 1'b0;
        else     par_bit <= par_n;
    end
    always_comb begin
        par_n = par_bit;
        if (!timeout_hit && fall && state == PARITY) par_n = data_s2;
    end
    assign frame_ok = data_s2 & (^{shift, par_bit});
`else
    assign frame_ok = data_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            byte_valid <= 1'b0;
            byte_reg   <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            byte_valid <= byte_done;
            frame_err  <= err_n;
            if (byte_done) byte_reg <= shift;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        byte_done = 1'b0;
        err_n     = 1'b0;
        // Expiry wins over a coincident edge: the frame is dropped and the edge is not sampled.
        if (timeout_hit) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s2) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shift_n   = {data_s2, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: state_n = STOP;
                STOP: begin
                    if (frame_ok) byte_done = 1'b1;
                    else          err_n     = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Saturating count of cycles since the last edge; held at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        to_cnt <= '0;
        else if (state == IDLE || fall) to_cnt <= '0;
        else if (to_cnt != '1)          to_cnt <= to_cnt + 1'b1;
    end

    always_comb begin
        code = 4'b0000;
        case (byte_reg)
            8'h1D:   code = 4'b0001;
            8'h75:   code = ext ? 4'b0001 : 4'b0000;
            8'h1B:   code = 4'b0010;
            8'h72:   code = ext ? 4'b0010 : 4'b0000;
            8'h5A:   code = 4'b0100;
            8'h76:   code = 4'b1000;
            default: code = 4'b0000;
        endcase
        key_n = keyboard_out;
        if (code != 4'b0000) begin
            if (!brk)                      key_n = code;
            else if (keyboard_out == code) key_n = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext          <= 1'b0;
            brk          <= 1'b0;
            keyboard_out <= 4'b0000;
            key_valid    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_valid) begin
                if (byte_reg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (byte_reg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext          <= 1'b0;
                    brk          <= 1'b0;
                    keyboard_out <= key_n;
                    key_valid    <= (key_n != keyboard_out);
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames from the board's PS/2 port and turns scan-code set 2 make/break sequences into the 4-bit `keyboard_in` code consumed by the menu and game logic. It sits between the top-level PS/2 pins and `game_menu`. It drives the key code that the menu page FSM steps on. It runs in the pixel clock domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65000: number of `clk` cycles with no PS/2 clock falling edge mid-frame before the receiver aborts the frame (about 1 ms at 65 MHz).

Ports:
- `clk`  input  1  system/pixel clock.
- `rst`  input  1  reset. Asynchronous and active-high.
- `ps2_clk`  input  1  raw PS/2 clock from the pin; asynchronous to `clk`.
- `ps2_data`  input  1  raw PS/2 data from the pin; asynchronous to `clk`.
- `keyboard_out`  output  4  current key code, connected to `keyboard_in`. Encoding:
  - 4'b0000 = none
  - 4'b0001 = up
  - 4'b0010 = down
  - 4'b0100 = enter
  - 4'b1000 = esc
- `key_valid`  output  1  one-cycle strobe whenever `keyboard_out` changes value.
- `frame_err`  output  1  one-cycle strobe when a frame is discarded.

## Operation
- **Synchronisation.** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. A falling edge of the synchronised clock produces a one-cycle `fall` pulse. `ps2_data` is sampled in the cycle where `fall` is high.
- **Receiver FSM:**
  - IDLE: on `fall` with data=0 (start bit), clear the bit counter and go to DATA. On `fall` with data=1, stay in IDLE (glitch).
  - DATA: shift 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: if data=1, the byte is complete and is handed to the decoder. If data=0, pulse `frame_err`. Either way, return to IDLE.
  - Any state other than IDLE: a timeout counter resets on each `fall`. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err` and return to IDLE.
- **Decoder** (flags `ext`, `brk`):
  - Byte E0: set `ext`.
  - Byte F0: set `brk`.
  - Any other byte is looked up using `ext`:
    - 1D (W), or 75 with `ext`: up.
    - 1B (S), or 72 with `ext`: down.
    - 5A: enter.
    - 76: esc.
  - Unknown code: ignored.
  - After any non-prefix byte, clear both `ext` and `brk`.
- **Output update:**
  - Make of a known key sets `keyboard_out` to that key's code.
  - Break of the key currently shown sets `keyboard_out` to 0.
  - Break of any other key is ignored.
  - Most recent make wins.
  - `key_valid` pulses only if the value actually changes; a typematic repeat of the same key gives no pulse.

## Timing
- Reset values:
  - `keyboard_out` = 0, `key_valid` = 0, `frame_err` = 0.
  - FSM in IDLE; `ext`, `brk` and timeout counter = 0.
- Latency: `keyboard_out` and `key_valid` update on the 2nd `clk` rising edge after the `fall` cycle of the stop bit. The first edge registers the byte; the second updates the output.
- `frame_err` asserts on the clock edge after the offending `fall` cycle, or after the timeout expiry, and lasts exactly 1 cycle.
- The timeout counter is at least 17 bits wide and saturates; it does not wrap.
- A `fall` in the same cycle as timeout expiry: the timeout takes priority. The frame is aborted and that edge is not sampled.
- Asserting `rst` mid-frame immediately returns every register to its reset value, and the partial byte is lost.
- Minimum PS/2 bit period (about 60 µs) is many thousands of `clk` cycles, so no back-pressure exists and a new frame can start in the cycle after STOP.

## Configuration
- `PS2_PARITY_CHECK_EN`
  - Defined: in STOP, the frame is accepted only if the 8 data bits plus the parity bit contain an odd number of ones. Otherwise `frame_err` pulses and the byte is dropped. A dropped byte does not change `ext` or `brk`.
  - Undefined: the parity bit is sampled but ignored, and only the stop bit is checked.

## Test plan
- Frame 5A (parity 1, stop 1), then frames F0, 5A → `keyboard_out` = 4'b0100 with one `key_valid` pulse, then 4'b0000 with a second pulse.
- Frames E0 75, then 1B, then F0 1B, then E0 F0 75 → `keyboard_out` goes 0001 → 0010 → 0000. The final break is ignored, and `key_valid` pulses exactly 3 times.
- Frame 5A sent three times with no break → one `key_valid` pulse, and `keyboard_out` stays 4'b0100.
- Frame 76 with the stop bit forced to 0 → `frame_err` pulses once and `keyboard_out` stays 0. A following clean 76 frame → 4'b1000.
- Start bit plus 3 data bits, then clock idle for `TIMEOUT_CYCLES` → `frame_err` pulses once. A following clean 1D frame decodes to 4'b0001.
- With `PS2_PARITY_CHECK_EN`, frame 1D with parity 0 → `frame_err` and no output change. Without the macro, the same frame → `keyboard_out` = 4'b0001.
